// File: rtl/residual_sq_accumulator_pkg.sv
// Shared widths and the frame FSM state type for the residual square accumulator.
// Imported by the interface, the residual_square stage and the top.
package RgbdVoConfigPk;

  localparam int DATA_RGB_BW = 8;
  localparam int H_SIZE_BW   = 5;
  localparam int V_SIZE_BW   = 5;

  localparam int RES_W = DATA_RGB_BW + 1;
  localparam int SQ_W  = 2 * DATA_RGB_BW + 2;
  localparam int CNT_W = H_SIZE_BW + V_SIZE_BW;
  localparam int SUM_W = H_SIZE_BW + V_SIZE_BW + 2 * DATA_RGB_BW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/residual_sq_accumulator_if.sv
// Pixel/frame stream into the accumulator and the published frame totals.
// The slave modport is the accumulator's view; master is the upstream producer's.
interface residual_sq_accumulator_if;
  import RgbdVoConfigPk::*;

  logic                    i_frame_start;
  logic                    i_frame_end;
  logic                    i_valid;
  logic                    i_corresp_valid;
  logic signed [RES_W-1:0] i_residual;
  logic                    o_frame_end;
  logic [SUM_W-1:0]        o_sigma_s_rgbd;
  logic [CNT_W-1:0]        o_corresp_count;
  logic                    o_count_zero;

  modport master (
    output i_frame_start, i_frame_end, i_valid, i_corresp_valid, i_residual,
    input  o_frame_end, o_sigma_s_rgbd, o_corresp_count, o_count_zero
  );

  modport slave (
    input  i_frame_start, i_frame_end, i_valid, i_corresp_valid, i_residual,
    output o_frame_end, o_sigma_s_rgbd, o_corresp_count, o_count_zero
  );

endinterface

// File: rtl/residual_sq_accumulator_data_delay.sv
// Generic reset-to-zero delay line used to keep control flags aligned with
// the registered datapath stages.
module DataDelay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/residual_sq_accumulator_residual_square.sv
// Stage 1: square of the signed residual, registered as an unsigned value.
module residual_square
  import RgbdVoConfigPk::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [RES_W-1:0] residual,
  output logic [SQ_W-1:0]         square
);

  logic signed [2*RES_W-1:0] product;

  // A signed square is never negative, so the full product reinterprets as unsigned
  assign product = residual * residual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) square <= '0;
    else        square <= $unsigned(product);
  end

endmodule

// File: rtl/residual_sq_accumulator.sv
// Per-frame sum of squared residuals and correspondence count, published two
// cycles after frame end. Define RESIDUAL_ACC_SATURATE_EN to clamp instead of wrap.
module residual_sq_accumulator
  import RgbdVoConfigPk::*;
(
  input logic                      i_clk,
  input logic                      i_rst_n,
  residual_sq_accumulator_if.slave bus
);

  acc_state_t       state, state_next;
  logic             in_accum, count_en, end_accept;
  logic [2:0]       aligned;
  logic             acc_en, clr, publish;
  logic [SQ_W-1:0]  square;
  logic [SUM_W-1:0] sum, sum_next, base_sum, sq_term, pub_sum;
  logic [CNT_W-1:0] cnt, cnt_next, base_cnt, inc, pub_cnt;
`ifdef RESIDUAL_ACC_SATURATE_EN
  logic             sum_carry, cnt_carry;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // A start always opens a fresh frame, even when it lands on a closing end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_frame_start) state_next = ACCUM;
      ACCUM:   if (bus.i_frame_start) state_next = ACCUM;
               else if (bus.i_frame_end) state_next = DONE;
      DONE:    state_next = bus.i_frame_start ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_accum   = (state == ACCUM);
    count_en   = bus.i_valid & bus.i_corresp_valid & (in_accum | bus.i_frame_start);
    end_accept = bus.i_frame_end & in_accum;
  end

  residual_square u_square (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .residual (bus.i_residual),
    .square   (square)
  );

  DataDelay #(.WIDTH(3), .DEPTH(1)) u_align (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   ({count_en, bus.i_frame_start, end_accept}),
    .dout  (aligned)
  );

  assign {acc_en, clr, publish} = aligned;

  // On a simultaneous close/open the aligned pixel belongs to the new frame,
  // so the closing totals are the stored ones rather than the updated ones.
  always_comb begin
    sq_term  = acc_en ? {{(SUM_W-SQ_W){1'b0}}, square} : '0;
    inc      = {{(CNT_W-1){1'b0}}, acc_en};
    base_sum = clr ? '0 : sum;
    base_cnt = clr ? '0 : cnt;
`ifdef RESIDUAL_ACC_SATURATE_EN
    {sum_carry, sum_next} = {1'b0, base_sum} + {1'b0, sq_term};
    {cnt_carry, cnt_next} = {1'b0, base_cnt} + {1'b0, inc};
    if (sum_carry) sum_next = '1;
    if (cnt_carry) cnt_next = '1;
`else
    sum_next = base_sum + sq_term;
    cnt_next = base_cnt + inc;
`endif
    pub_sum = clr ? sum : sum_next;
    pub_cnt = clr ? cnt : cnt_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum                 <= '0;
      cnt                 <= '0;
      bus.o_frame_end     <= 1'b0;
      bus.o_sigma_s_rgbd  <= '0;
      bus.o_corresp_count <= '0;
      bus.o_count_zero    <= 1'b0;
    end else begin
      sum             <= sum_next;
      cnt             <= cnt_next;
      bus.o_frame_end <= publish;
      if (publish) begin
        bus.o_sigma_s_rgbd  <= pub_sum;
        bus.o_corresp_count <= pub_cnt;
        bus.o_count_zero    <= (pub_cnt == '0);
      end
    end
  end

endmodule
